// File: rtl/axi_ar_dispatch_pkg.sv
// Shared types and constants for the AXI read-address dispatcher.
// Holds the dispatcher FSM state encoding and the AXI DECERR response code
// used by the error responder that consumes error_req_o.
package axi_ar_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_SWITCH = 2'd1,
        ST_ERROR_REQ   = 2'd2
    } ar_state_e;

    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_ar_addr_decoder.sv
// Combinational address decoder: compares an address against N inclusive
// [start, end] regions, keeps only enabled ones, and returns the lowest
// matching region as a one-hot vector plus a miss flag.
module axi_ar_addr_decoder #(
    parameter int N_INIT_PORT   = 4,
    parameter int AXI_ADDRESS_W = 32
) (
    input  logic [AXI_ADDRESS_W-1:0]                  addr,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] start_addr,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] end_addr,
    input  logic [N_INIT_PORT-1:0]                    enable_region,
    output logic [N_INIT_PORT-1:0]                    hit,
    output logic                                      miss
);

    logic [N_INIT_PORT-1:0] match_s;

    // Per-region unsigned inclusive range match, masked by region enable
    always_comb begin
        match_s = '0;
        for (int j = 0; j < N_INIT_PORT; j++) begin
            if (enable_region[j] && (addr >= start_addr[j]) && (addr <= end_addr[j])) begin
                match_s[j] = 1'b1;
            end else begin
                match_s[j] = 1'b0;
            end
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index
    assign hit  = match_s & (~match_s + N_INIT_PORT'(1));
    assign miss = ~|match_s;

endmodule

// File: rtl/axi_ar_dispatcher.sv
// AXI AR channel dispatcher for one source port.
// Decodes each read address to a destination port, holds off a switch of
// destination while reads are still outstanding on the previous one, stalls
// while the response tracker is full, and diverts unmapped addresses to a
// DECERR responder (error_req_o / error_gnt_i) after capturing len/user/id.
// Optional feature macro: AXI_AR_DISPATCH_PIPE_EN -- when defined, hit ARs
// pass through a one-entry output register (1-cycle latency, full
// throughput); when undefined the hit path is combinational.
module axi_ar_dispatcher
    import axi_ar_dispatch_pkg::*;
#(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_ID_IN     = 16,
    parameter int AXI_USER_W    = 6,
    parameter int N_INIT_PORT   = 4,
    parameter int N_TARG_PORT   = 8,
    parameter int TARG_IDX      = 0,
    parameter int AXI_ID_OUT    = AXI_ID_IN + $clog2(N_TARG_PORT)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [AXI_ID_IN-1:0]                      arid_i,
    input  logic [AXI_ADDRESS_W-1:0]                  araddr_i,
    input  logic [7:0]                                arlen_i,
    input  logic [2:0]                                arsize_i,
    input  logic [1:0]                                arburst_i,
    input  logic                                      arlock_i,
    input  logic [3:0]                                arcache_i,
    input  logic [2:0]                                arprot_i,
    input  logic [3:0]                                arregion_i,
    input  logic [3:0]                                arqos_i,
    input  logic [AXI_USER_W-1:0]                     aruser_i,
    input  logic                                      arvalid_i,
    output logic                                      arready_o,
    output logic [AXI_ID_OUT-1:0]                     arid_o,
    output logic [AXI_ADDRESS_W-1:0]                  araddr_o,
    output logic [7:0]                                arlen_o,
    output logic [2:0]                                arsize_o,
    output logic [1:0]                                arburst_o,
    output logic                                      arlock_o,
    output logic [3:0]                                arcache_o,
    output logic [2:0]                                arprot_o,
    output logic [3:0]                                arregion_o,
    output logic [3:0]                                arqos_o,
    output logic [AXI_USER_W-1:0]                     aruser_o,
    output logic [N_INIT_PORT-1:0]                    arvalid_o,
    input  logic [N_INIT_PORT-1:0]                    arready_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] start_addr_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] end_addr_i,
    input  logic [N_INIT_PORT-1:0]                    enable_region_i,
    output logic                                      incr_req_o,
    input  logic                                      full_counter_i,
    input  logic                                      outstanding_trans_i,
    output logic                                      error_req_o,
    input  logic                                      error_gnt_i,
    output logic [7:0]                                error_len_o,
    output logic [AXI_USER_W-1:0]                     error_user_o,
    output logic [AXI_ID_IN-1:0]                      error_id_o,
    output logic                                      sample_ardata_info_o
);

    localparam int DW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
    localparam int TW = AXI_ID_OUT - AXI_ID_IN;
    localparam int PW = AXI_ID_IN + AXI_ADDRESS_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + AXI_USER_W;

    localparam logic [TW-1:0] TARG_ID = TW'(TARG_IDX);

    ar_state_e               state_r, state_s;
    logic [DW-1:0]           last_dest_r;
    logic [DW-1:0]           dest_idx_s;
    logic [N_INIT_PORT-1:0]  hit_s;
    logic                    miss_s;
    logic                    accept_s;
    logic                    miss_take_s;
    logic                    pipe_busy_s;
    logic                    upd_last_s;
    logic [N_INIT_PORT-1:0]  arvalid_s;
    logic                    arready_s;
    logic                    incr_s;
    logic [7:0]              error_len_r;
    logic [AXI_USER_W-1:0]   error_user_r;
    logic [AXI_ID_IN-1:0]    error_id_r;
    logic [PW-1:0]           payload_in_s;

    axi_ar_addr_decoder #(
        .N_INIT_PORT   (N_INIT_PORT),
        .AXI_ADDRESS_W (AXI_ADDRESS_W)
    ) u_decoder (
        .addr          (araddr_i),
        .start_addr    (start_addr_i),
        .end_addr      (end_addr_i),
        .enable_region (enable_region_i),
        .hit           (hit_s),
        .miss          (miss_s)
    );

    assign payload_in_s = {arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i,
                           arcache_i, arprot_i, arregion_i, arqos_i, aruser_i};

    // Encode the one-hot hit vector into a destination index
    always_comb begin
        dest_idx_s = '0;
        for (int j = 0; j < N_INIT_PORT; j++) begin
            if (hit_s[j]) begin
                dest_idx_s = DW'(j);
            end else begin
                dest_idx_s = dest_idx_s;
            end
        end
    end

    // Next-state decision: accept a hit, divert a miss, or hold for a destination switch
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        miss_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arvalid_i && !full_counter_i) begin
                    if (miss_s) begin
                        miss_take_s = 1'b1;
                        state_s     = ST_ERROR_REQ;
                    end else if ((dest_idx_s == last_dest_r) ||
                                 (!outstanding_trans_i && !pipe_busy_s)) begin
                        accept_s = 1'b1;
                    end else if (outstanding_trans_i) begin
                        state_s = ST_WAIT_SWITCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_SWITCH: begin
                if (!outstanding_trans_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_SWITCH;
                end
            end
            ST_ERROR_REQ: begin
                if (error_gnt_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERROR_REQ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and last-used destination; only forwarded ARs update last_dest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            last_dest_r <= '0;
        end else begin
            state_r <= state_s;
            if (upd_last_s) begin
                last_dest_r <= dest_idx_s;
            end else begin
                last_dest_r <= last_dest_r;
            end
        end
    end

    // Capture the missed AR's len/user/id for the DECERR responder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_len_r  <= 8'd0;
            error_user_r <= '0;
            error_id_r   <= '0;
        end else if (miss_take_s) begin
            error_len_r  <= arlen_i;
            error_user_r <= aruser_i;
            error_id_r   <= arid_i;
        end else begin
            error_len_r  <= error_len_r;
            error_user_r <= error_user_r;
            error_id_r   <= error_id_r;
        end
    end

`ifdef AXI_AR_DISPATCH_PIPE_EN
    logic                   reg_valid_r;
    logic [N_INIT_PORT-1:0] reg_oh_r;
    logic [PW-1:0]          reg_pl_r;
    logic                   hs_down_s;
    logic                   load_s;

    assign pipe_busy_s = reg_valid_r;

    // Registered hit path: drain on downstream handshake, refill in the same cycle
    always_comb begin
        arvalid_s = '0;
        if (reg_valid_r && !full_counter_i) begin
            arvalid_s = reg_oh_r;
        end else begin
            arvalid_s = '0;
        end
        hs_down_s  = |(arvalid_s & arready_i);
        load_s     = accept_s & (!reg_valid_r | hs_down_s);
        arready_s  = miss_take_s | load_s;
        incr_s     = hs_down_s;
        upd_last_s = load_s;
    end

    // One-entry output register holding the accepted AR and its destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_valid_r <= 1'b0;
            reg_oh_r    <= '0;
            reg_pl_r    <= '0;
        end else if (load_s) begin
            reg_valid_r <= 1'b1;
            reg_oh_r    <= hit_s;
            reg_pl_r    <= payload_in_s;
        end else if (hs_down_s) begin
            reg_valid_r <= 1'b0;
            reg_oh_r    <= reg_oh_r;
            reg_pl_r    <= reg_pl_r;
        end else begin
            reg_valid_r <= reg_valid_r;
            reg_oh_r    <= reg_oh_r;
            reg_pl_r    <= reg_pl_r;
        end
    end

    logic [AXI_ID_IN-1:0] reg_id_s;
    assign {reg_id_s, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
            arcache_o, arprot_o, arregion_o, arqos_o, aruser_o} = reg_pl_r;
    assign arid_o = {TARG_ID, reg_id_s};
`else
    assign pipe_busy_s = 1'b0;

    // Combinational hit path: present the AR to the decoded destination directly
    always_comb begin
        arvalid_s = '0;
        if (accept_s) begin
            arvalid_s = hit_s;
        end else begin
            arvalid_s = '0;
        end
        incr_s     = |(arvalid_s & arready_i);
        arready_s  = miss_take_s | incr_s;
        upd_last_s = incr_s;
    end

    logic [AXI_ID_IN-1:0] pass_id_s;
    assign {pass_id_s, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
            arcache_o, arprot_o, arregion_o, arqos_o, aruser_o} = payload_in_s;
    assign arid_o = {TARG_ID, pass_id_s};
`endif

    assign arvalid_o            = arvalid_s;
    assign arready_o            = arready_s;
    assign incr_req_o           = incr_s;
    assign sample_ardata_info_o = miss_take_s;
    assign error_req_o          = (state_r == ST_ERROR_REQ);
    assign error_len_o          = error_len_r;
    assign error_user_o         = error_user_r;
    assign error_id_o           = error_id_r;

endmodule

// File: tb/tb_axi_ar_dispatcher.sv
// Directed self-checking bench for axi_ar_dispatcher (default build:
// combinational hit path). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_axi_ar_dispatcher;

    localparam int AW  = 32;
    localparam int IDW = 16;
    localparam int UW  = 6;
    localparam int NI  = 4;
    localparam int NT  = 8;
    localparam int TI  = 5;
    localparam int IDO = IDW + $clog2(NT);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [IDW-1:0]         arid_i;
    logic [AW-1:0]          araddr_i;
    logic [7:0]             arlen_i;
    logic [2:0]             arsize_i;
    logic [1:0]             arburst_i;
    logic                   arlock_i;
    logic [3:0]             arcache_i;
    logic [2:0]             arprot_i;
    logic [3:0]             arregion_i;
    logic [3:0]             arqos_i;
    logic [UW-1:0]          aruser_i;
    logic                   arvalid_i;
    logic                   arready_o;
    logic [IDO-1:0]         arid_o;
    logic [AW-1:0]          araddr_o;
    logic [7:0]             arlen_o;
    logic [2:0]             arsize_o;
    logic [1:0]             arburst_o;
    logic                   arlock_o;
    logic [3:0]             arcache_o;
    logic [2:0]             arprot_o;
    logic [3:0]             arregion_o;
    logic [3:0]             arqos_o;
    logic [UW-1:0]          aruser_o;
    logic [NI-1:0]          arvalid_o;
    logic [NI-1:0]          arready_i;
    logic [NI-1:0][AW-1:0]  start_addr_i;
    logic [NI-1:0][AW-1:0]  end_addr_i;
    logic [NI-1:0]          enable_region_i;
    logic                   incr_req_o;
    logic                   full_counter_i;
    logic                   outstanding_trans_i;
    logic                   error_req_o;
    logic                   error_gnt_i;
    logic [7:0]             error_len_o;
    logic [UW-1:0]          error_user_o;
    logic [IDW-1:0]         error_id_o;
    logic                   sample_ardata_info_o;

    int n_checks = 0;
    int n_errors = 0;

    axi_ar_dispatcher #(
        .AXI_ADDRESS_W (AW),
        .AXI_ID_IN     (IDW),
        .AXI_USER_W    (UW),
        .N_INIT_PORT   (NI),
        .N_TARG_PORT   (NT),
        .TARG_IDX      (TI)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .arid_i               (arid_i),
        .araddr_i             (araddr_i),
        .arlen_i              (arlen_i),
        .arsize_i             (arsize_i),
        .arburst_i            (arburst_i),
        .arlock_i             (arlock_i),
        .arcache_i            (arcache_i),
        .arprot_i             (arprot_i),
        .arregion_i           (arregion_i),
        .arqos_i              (arqos_i),
        .aruser_i             (aruser_i),
        .arvalid_i            (arvalid_i),
        .arready_o            (arready_o),
        .arid_o               (arid_o),
        .araddr_o             (araddr_o),
        .arlen_o              (arlen_o),
        .arsize_o             (arsize_o),
        .arburst_o            (arburst_o),
        .arlock_o             (arlock_o),
        .arcache_o            (arcache_o),
        .arprot_o             (arprot_o),
        .arregion_o           (arregion_o),
        .arqos_o              (arqos_o),
        .aruser_o             (aruser_o),
        .arvalid_o            (arvalid_o),
        .arready_i            (arready_i),
        .start_addr_i         (start_addr_i),
        .end_addr_i           (end_addr_i),
        .enable_region_i      (enable_region_i),
        .incr_req_o           (incr_req_o),
        .full_counter_i       (full_counter_i),
        .outstanding_trans_i  (outstanding_trans_i),
        .error_req_o          (error_req_o),
        .error_gnt_i          (error_gnt_i),
        .error_len_o          (error_len_o),
        .error_user_o         (error_user_o),
        .error_id_o           (error_id_o),
        .sample_ardata_info_o (sample_ardata_info_o)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_ar(input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                            input logic [7:0] len, input logic [UW-1:0] user);
        araddr_i  = addr;
        arid_i    = id;
        arlen_i   = len;
        aruser_i  = user;
        arvalid_i = 1'b1;
    endtask

    initial begin
        rst_n               = 1'b0;
        arid_i              = '0;
        araddr_i            = '0;
        arlen_i             = 8'd0;
        arsize_i            = 3'd2;
        arburst_i           = 2'd1;
        arlock_i            = 1'b0;
        arcache_i           = 4'd3;
        arprot_i            = 3'd0;
        arregion_i          = 4'd0;
        arqos_i             = 4'd0;
        aruser_i            = '0;
        arvalid_i           = 1'b0;
        arready_i           = '0;
        full_counter_i      = 1'b0;
        outstanding_trans_i = 1'b0;
        error_gnt_i         = 1'b0;
        // R0 0x4000-0x4FFF, R1 0x1000-0x1FFF, R2 0x2000-0x4FFF (overlaps R0), R3 disabled
        start_addr_i[0] = 32'h0000_4000; end_addr_i[0] = 32'h0000_4FFF;
        start_addr_i[1] = 32'h0000_1000; end_addr_i[1] = 32'h0000_1FFF;
        start_addr_i[2] = 32'h0000_2000; end_addr_i[2] = 32'h0000_4FFF;
        start_addr_i[3] = 32'h0000_8000; end_addr_i[3] = 32'h0000_8FFF;
        enable_region_i = 4'b0111;

        // Reset state
        tick(); tick();
        mid();
        chk("rst_arvalid", 64'(arvalid_o), 64'(4'b0000));
        chk("rst_error_req", 64'(error_req_o), 64'd0);
        chk("rst_incr", 64'(incr_req_o), 64'd0);
        chk("rst_sample", 64'(sample_ardata_info_o), 64'd0);
        chk("rst_error_len", 64'(error_len_o), 64'd0);
        chk("rst_error_id", 64'(error_id_o), 64'd0);
        tick();
        rst_n = 1'b1;

        // Basic hit to region 1 with ready
        tick();
        drive_ar(32'h0000_1800, 16'h1234, 8'd3, 6'h05);
        arready_i = 4'b0010;
        mid();
        chk("hit1_arvalid", 64'(arvalid_o), 64'(4'b0010));
        chk("hit1_arready", 64'(arready_o), 64'd1);
        chk("hit1_incr", 64'(incr_req_o), 64'd1);
        chk("hit1_arid", 64'(arid_o), 64'({3'd5, 16'h1234}));
        chk("hit1_araddr", 64'(araddr_o), 64'(32'h0000_1800));
        chk("hit1_arlen", 64'(arlen_o), 64'd3);
        tick();
        arvalid_i = 1'b0;
        mid();
        chk("hit1_incr_off", 64'(incr_req_o), 64'd0);
        chk("hit1_arvalid_off", 64'(arvalid_o), 64'(4'b0000));

        // Region start boundary with downstream not ready: valid held until handshake
        tick();
        drive_ar(32'h0000_1000, 16'h0001, 8'd0, 6'h00);
        arready_i = 4'b0000;
        mid();
        chk("hold_arvalid0", 64'(arvalid_o), 64'(4'b0010));
        chk("hold_arready0", 64'(arready_o), 64'd0);
        chk("hold_incr0", 64'(incr_req_o), 64'd0);
        tick();
        mid();
        chk("hold_arvalid1", 64'(arvalid_o), 64'(4'b0010));
        tick();
        arready_i = 4'b0010;
        mid();
        chk("hold_incr_hs", 64'(incr_req_o), 64'd1);
        tick();
        // Region end boundary still hits region 1
        drive_ar(32'h0000_1FFF, 16'h0002, 8'd1, 6'h00);
        mid();
        chk("end_bound_arvalid", 64'(arvalid_o), 64'(4'b0010));
        tick();
        arvalid_i = 1'b0;

        // Destination switch 1 -> 2 with reads outstanding
        tick();
        drive_ar(32'h0000_2800, 16'h0003, 8'd2, 6'h00);
        outstanding_trans_i = 1'b1;
        arready_i = 4'b0100;
        mid();
        chk("sw_idle_arvalid", 64'(arvalid_o), 64'(4'b0000));
        chk("sw_idle_arready", 64'(arready_o), 64'd0);
        tick();
        mid();
        chk("sw_wait_arvalid", 64'(arvalid_o), 64'(4'b0000));
        tick();
        outstanding_trans_i = 1'b0;
        mid();
        chk("sw_drop_arvalid", 64'(arvalid_o), 64'(4'b0000));
        tick();
        mid();
        chk("sw_go_arvalid", 64'(arvalid_o), 64'(4'b0100));
        chk("sw_go_incr", 64'(incr_req_o), 64'd1);
        tick();
        arvalid_i = 1'b0;

        // Full counter back-pressure, then AR forwarded intact
        tick();
        drive_ar(32'h0000_2100, 16'hA5A5, 8'd9, 6'h11);
        arready_i = 4'b1111;
        full_counter_i = 1'b1;
        mid();
        chk("full_arvalid0", 64'(arvalid_o), 64'(4'b0000));
        chk("full_arready0", 64'(arready_o), 64'd0);
        chk("full_incr0", 64'(incr_req_o), 64'd0);
        tick();
        mid();
        chk("full_arvalid1", 64'(arvalid_o), 64'(4'b0000));
        tick();
        full_counter_i = 1'b0;
        mid();
        chk("full_rel_arvalid", 64'(arvalid_o), 64'(4'b0100));
        chk("full_rel_araddr", 64'(araddr_o), 64'(32'h0000_2100));
        chk("full_rel_arid", 64'(arid_o), 64'({3'd5, 16'hA5A5}));
        chk("full_rel_aruser", 64'(aruser_o), 64'(6'h11));
        tick();
        arvalid_i = 1'b0;

        // Overlap of regions 0 and 2: lowest index wins
        tick();
        drive_ar(32'h0000_4800, 16'h0004, 8'd0, 6'h00);
        mid();
        chk("overlap_arvalid", 64'(arvalid_o), 64'(4'b0001));
        tick();
        arvalid_i = 1'b0;

        // Miss: error capture, hold until grant
        tick();
        drive_ar(32'h0000_9000, 16'hBEEF, 8'd7, 6'h2A);
        mid();
        chk("miss_arready", 64'(arready_o), 64'd1);
        chk("miss_sample", 64'(sample_ardata_info_o), 64'd1);
        chk("miss_arvalid", 64'(arvalid_o), 64'(4'b0000));
        chk("miss_incr", 64'(incr_req_o), 64'd0);
        tick();
        drive_ar(32'h0000_1800, 16'h0005, 8'd0, 6'h00);
        mid();
        chk("err_req", 64'(error_req_o), 64'd1);
        chk("err_len", 64'(error_len_o), 64'd7);
        chk("err_user", 64'(error_user_o), 64'(6'h2A));
        chk("err_id", 64'(error_id_o), 64'(16'hBEEF));
        chk("err_arready", 64'(arready_o), 64'd0);
        chk("err_arvalid", 64'(arvalid_o), 64'(4'b0000));
        chk("err_sample", 64'(sample_ardata_info_o), 64'd0);
        tick();
        arvalid_i = 1'b0;
        mid();
        chk("err_req_held", 64'(error_req_o), 64'd1);
        tick();
        error_gnt_i = 1'b1;
        mid();
        chk("err_req_gnt", 64'(error_req_o), 64'd1);
        tick();
        error_gnt_i = 1'b0;
        mid();
        chk("err_req_done", 64'(error_req_o), 64'd0);

        // last_dest still 0 after miss: region-0 AR goes with reads outstanding
        tick();
        drive_ar(32'h0000_4100, 16'h0006, 8'd0, 6'h00);
        outstanding_trans_i = 1'b1;
        mid();
        chk("keep_last_arvalid", 64'(arvalid_o), 64'(4'b0001));
        tick();
        arvalid_i = 1'b0;
        outstanding_trans_i = 1'b0;

        // Miss into disabled region 3, then reset while requesting DECERR
        tick();
        drive_ar(32'h0000_8800, 16'h0077, 8'd4, 6'h01);
        mid();
        chk("dis_miss_sample", 64'(sample_ardata_info_o), 64'd1);
        tick();
        arvalid_i = 1'b0;
        mid();
        chk("dis_err_req", 64'(error_req_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_err_req", 64'(error_req_o), 64'd0);
        chk("rst_err_id", 64'(error_id_o), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        drive_ar(32'h0000_1800, 16'h0042, 8'd1, 6'h00);
        arready_i = 4'b0010;
        mid();
        chk("post_rst_arvalid", 64'(arvalid_o), 64'(4'b0010));
        chk("post_rst_incr", 64'(incr_req_o), 64'd1);
        chk("post_rst_err_req", 64'(error_req_o), 64'd0);
        tick();
        arvalid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
